// File: rtl/rgb565_color_tracker.sv
// rgb565_color_tracker: taps the camera frame-buffer write stream, classifies
// each RGB565 pixel against a colour threshold and accumulates match count,
// bounding box and coordinate sums. At frame end a restoring divider (one
// quotient bit per cycle) produces the centroid, presented on valid/ready.
// Optional build macro: TRACKER_ROI_EN restricts matching to the ROI window.
module rgb565_color_tracker #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int R_MIN      = 20,
  parameter int G_MAX      = 20,
  parameter int B_MAX      = 10,
  parameter int ROI_X0     = 0,
  parameter int ROI_X1     = IMG_WIDTH-1,
  parameter int ROI_Y0     = 0,
  parameter int ROI_Y1     = IMG_HEIGHT-1,
  localparam int X_W       = $clog2(IMG_WIDTH),
  localparam int Y_W       = $clog2(IMG_HEIGHT),
  localparam int CNT_W     = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
  localparam int SUM_W     = CNT_W + ((X_W > Y_W) ? X_W : Y_W)
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [15:0]           wData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  found,
  output logic [CNT_W-1:0]      pix_count,
  output logic [X_W-1:0]        cx,
  output logic [Y_W-1:0]        cy,
  output logic [X_W-1:0]        x_min,
  output logic [X_W-1:0]        x_max,
  output logic [Y_W-1:0]        y_min,
  output logic [Y_W-1:0]        y_max,
  output logic                  overrun
);

  localparam int BC_W = $clog2(SUM_W);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT-1);
  localparam logic [X_W-1:0]  X_LAST   = X_W'(IMG_WIDTH-1);
  localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(IMG_HEIGHT-1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(SUM_W-1);
  localparam logic [4:0]      R_MIN_V  = 5'(R_MIN);
  localparam logic [5:0]      G_MAX_V  = 6'(G_MAX);
  localparam logic [4:0]      B_MAX_V  = 5'(B_MAX);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
  state_t state_reg, state_next;

  // Position counters and running accumulators
  logic [X_W-1:0]   x_reg, x_next, pos_x;
  logic [Y_W-1:0]   y_reg, y_next, pos_y;
  logic [CNT_W-1:0] cnt_reg, cnt_next, fold_cnt;
  logic [SUM_W-1:0] sx_reg, sx_next, fold_sx;
  logic [SUM_W-1:0] sy_reg, sy_next, fold_sy;
  logic [X_W-1:0]   xmin_reg, xmin_next, fold_xmin, xmax_reg, xmax_next, fold_xmax;
  logic [Y_W-1:0]   ymin_reg, ymin_next, fold_ymin, ymax_reg, ymax_next, fold_ymax;
  logic             frame_start, frame_end, in_roi, match;

  // Snapshot taken at frame end and divider state
  logic [CNT_W-1:0] snap_cnt_reg;
  logic [SUM_W-1:0] snap_sy_reg;
  logic [X_W-1:0]   snap_xmin_reg, snap_xmax_reg;
  logic [Y_W-1:0]   snap_ymin_reg, snap_ymax_reg;
  logic [SUM_W-1:0] div_reg, quot_reg, quot_shift;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [CNT_W:0]   rem_shift, rem_diff;
  logic             q_bit;
  logic [BC_W-1:0]  bit_reg;
  logic [X_W-1:0]   qx_reg;
  logic [Y_W-1:0]   qy_reg;
  logic             busy, last_bit, accept_snap;

  assign frame_start = we && (wAddr == '0);
  assign frame_end   = we && (wAddr == LAST_ADDR);
  assign busy        = (state_reg == DIV_X) || (state_reg == DIV_Y);
  assign last_bit    = (bit_reg == BIT_LAST);
  assign accept_snap = frame_end && !busy;

  // Address 0 forces position (0,0) so a restarted stream realigns at once
  assign pos_x = frame_start ? '0 : x_reg;
  assign pos_y = frame_start ? '0 : y_reg;

`ifdef TRACKER_ROI_EN
  assign in_roi = (int'(pos_x) >= ROI_X0) && (int'(pos_x) <= ROI_X1) &&
                  (int'(pos_y) >= ROI_Y0) && (int'(pos_y) <= ROI_Y1);
`else
  logic unused_roi;
  assign unused_roi = ^{ROI_X0, ROI_X1, ROI_Y0, ROI_Y1};
  assign in_roi     = 1'b1;
`endif

  assign match = we && in_roi && (wData[15:11] >= R_MIN_V) &&
                 (wData[10:5] <= G_MAX_V) && (wData[4:0] <= B_MAX_V);

  // Fold the current pixel into the (possibly restarted) accumulators
  always_comb begin
    fold_cnt  = frame_start ? '0 : cnt_reg;
    fold_sx   = frame_start ? '0 : sx_reg;
    fold_sy   = frame_start ? '0 : sy_reg;
    fold_xmin = frame_start ? X_LAST : xmin_reg;
    fold_xmax = frame_start ? '0 : xmax_reg;
    fold_ymin = frame_start ? Y_LAST : ymin_reg;
    fold_ymax = frame_start ? '0 : ymax_reg;
    if (match) begin
      fold_cnt = fold_cnt + 1'b1;
      fold_sx  = fold_sx + SUM_W'(pos_x);
      fold_sy  = fold_sy + SUM_W'(pos_y);
      if (pos_x < fold_xmin) fold_xmin = pos_x;
      if (pos_x > fold_xmax) fold_xmax = pos_x;
      if (pos_y < fold_ymin) fold_ymin = pos_y;
      if (pos_y > fold_ymax) fold_ymax = pos_y;
    end
  end

  // Next accumulator/position values; frame end hands off and clears
  always_comb begin
    cnt_next  = fold_cnt;
    sx_next   = fold_sx;
    sy_next   = fold_sy;
    xmin_next = fold_xmin;
    xmax_next = fold_xmax;
    ymin_next = fold_ymin;
    ymax_next = fold_ymax;
    x_next    = x_reg;
    y_next    = y_reg;
    if (frame_end) begin
      cnt_next  = '0;
      sx_next   = '0;
      sy_next   = '0;
      xmin_next = X_LAST;
      xmax_next = '0;
      ymin_next = Y_LAST;
      ymax_next = '0;
    end
    if (we) begin
      if (pos_x == X_LAST) begin
        x_next = '0;
        y_next = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
      end else begin
        x_next = pos_x + 1'b1;
        y_next = pos_y;
      end
    end
  end

  // One restoring-division step: shift in next dividend bit, try subtract
  always_comb begin
    rem_shift  = {rem_reg, div_reg[SUM_W-1]};
    rem_diff   = rem_shift - {1'b0, snap_cnt_reg};
    q_bit      = (rem_shift >= {1'b0, snap_cnt_reg});
    rem_next   = q_bit ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
    quot_shift = {quot_reg[SUM_W-2:0], q_bit};
  end

  // FSM next state: two fixed-length divides then a one-cycle publish
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (frame_end) state_next = DIV_X;
      DIV_X: if (last_bit) state_next = DIV_Y;
      DIV_Y: if (last_bit) state_next = DONE;
      DONE:  state_next = frame_end ? DIV_X : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Accumulators, snapshot and divider datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg <= '0;  y_reg <= '0;
      cnt_reg <= '0; sx_reg <= '0; sy_reg <= '0;
      xmin_reg <= X_LAST; xmax_reg <= '0;
      ymin_reg <= Y_LAST; ymax_reg <= '0;
      snap_cnt_reg <= '0; snap_sy_reg <= '0;
      snap_xmin_reg <= '0; snap_xmax_reg <= '0;
      snap_ymin_reg <= '0; snap_ymax_reg <= '0;
      div_reg <= '0; quot_reg <= '0; rem_reg <= '0; bit_reg <= '0;
      qx_reg <= '0; qy_reg <= '0;
    end else begin
      x_reg <= x_next;  y_reg <= y_next;
      cnt_reg <= cnt_next; sx_reg <= sx_next; sy_reg <= sy_next;
      xmin_reg <= xmin_next; xmax_reg <= xmax_next;
      ymin_reg <= ymin_next; ymax_reg <= ymax_next;
      if (accept_snap) begin
        snap_cnt_reg  <= fold_cnt;
        snap_sy_reg   <= fold_sy;
        snap_xmin_reg <= fold_xmin;
        snap_xmax_reg <= fold_xmax;
        snap_ymin_reg <= fold_ymin;
        snap_ymax_reg <= fold_ymax;
        div_reg  <= fold_sx;
        quot_reg <= '0;
        rem_reg  <= '0;
        bit_reg  <= '0;
      end else if (busy) begin
        if (last_bit) begin
          // Quotient is always below the image size, so truncation is lossless
          if (state_reg == DIV_X) begin
            qx_reg   <= quot_shift[X_W-1:0];
            div_reg  <= snap_sy_reg;
            quot_reg <= '0;
            rem_reg  <= '0;
            bit_reg  <= '0;
          end else begin
            qy_reg <= quot_shift[Y_W-1:0];
          end
        end else begin
          div_reg  <= {div_reg[SUM_W-2:0], 1'b0};
          quot_reg <= quot_shift;
          rem_reg  <= rem_next;
          bit_reg  <= bit_reg + 1'b1;
        end
      end
    end
  end

  // Result registers, valid/ready handshake and overrun pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0; found <= 1'b0; pix_count <= '0;
      cx <= '0; cy <= '0;
      x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= ((state_reg == DONE) && out_valid && !out_ready) || (frame_end && busy);
      if (state_reg == DONE) begin
        out_valid <= 1'b1;
        pix_count <= snap_cnt_reg;
        if (snap_cnt_reg == '0) begin
          // Empty frame: divider output is meaningless, publish all zeros
          found <= 1'b0;
          cx <= '0; cy <= '0;
          x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
        end else begin
          found <= 1'b1;
          cx <= qx_reg; cy <= qy_reg;
          x_min <= snap_xmin_reg; x_max <= snap_xmax_reg;
          y_min <= snap_ymin_reg; y_max <= snap_ymax_reg;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb565_color_tracker.sv
// Testbench for rgb565_color_tracker: table of single-frame vectors with
// hand-computed results, plus sequences for overrun, ready-at-publish,
// mid-frame restart and reset during the divide.
module tb_rgb565_color_tracker;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int AW   = 15;
  localparam int CW   = 15;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int LAST = W*H-1;
  localparam int LAT  = 47;

  logic          clk, reset, we, out_ready;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          out_valid, found, overrun;
  logic [CW-1:0] pix_count;
  logic [XW-1:0] cx, x_min, x_max;
  logic [YW-1:0] cy, y_min, y_max;

  int n_checks, n_fail, ovr_cnt;

  rgb565_color_tracker dut (
    .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData),
    .out_valid(out_valid), .out_ready(out_ready), .found(found),
    .pix_count(pix_count), .cx(cx), .cy(cy),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count overrun pulses, sampled mid-cycle
  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          px, py, bs;
    logic [15:0] color;
    bit          full;
    int          f, c, x, y, x0, x1, y0, y1;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_px(input int addr, input logic [15:0] d);
    we = 1'b1; wAddr = AW'(addr); wData = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Raster frame: bs x bs block of 'color' at (px,py), rest black. Short
  // frames stop after the block and are closed by a write to the last address.
  task automatic send_frame(input int px, input int py, input int bs,
                            input logic [15:0] color, input bit full);
    int last_idx, x, y;
    if (full) last_idx = LAST;
    else if (bs == 0) last_idx = 0;
    else last_idx = (py+bs-1)*W + px + bs - 1;
    for (int i = 0; i <= last_idx; i++) begin
      x = i % W; y = i / W;
      write_px(i, (bs > 0 && x >= px && x < px+bs && y >= py && y < py+bs) ? color : 16'h0000);
    end
    if (last_idx != LAST) write_px(LAST, 16'h0000);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= LAT+20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
  endtask

  task automatic check_out(input string tag, input int f, input int c, input int x, input int y,
                           input int x0, input int x1, input int y0, input int y1);
    chk({tag, " found"}, int'(found), f);
    chk({tag, " pix_count"}, int'(pix_count), c);
    chk({tag, " cx"}, int'(cx), x);
    chk({tag, " cy"}, int'(cy), y);
    chk({tag, " x_min"}, int'(x_min), x0);
    chk({tag, " x_max"}, int'(x_max), x1);
    chk({tag, " y_min"}, int'(y_min), y0);
    chk({tag, " y_max"}, int'(y_max), y1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int lat, o0, seen;
    n_checks = 0; n_fail = 0; ovr_cnt = 0;
    we = 1'b0; wAddr = '0; wData = '0; out_ready = 1'b0; reset = 1'b1;

    //            px   py  bs color     full  f  c   cx  cy  x0  x1  y0  y1
    vecs[0] = '{  0,   0, 0, 16'h0000, 1'b1, 0, 0,  0,  0,  0,  0,  0,  0};
    vecs[1] = '{ 10,  20, 1, 16'hF800, 1'b1, 1, 1, 10, 20, 10, 10, 20, 20};
    vecs[2] = '{ 40,  60, 4, 16'hF800, 1'b0, 1, 16, 41, 61, 40, 43, 60, 63};
    vecs[3] = '{  0,   0, 1, 16'hA28A, 1'b0, 1, 1,  0,  0,  0,  0,  0,  0};
    vecs[4] = '{  5,   1, 1, 16'h9A8A, 1'b0, 0, 0,  0,  0,  0,  0,  0,  0};
    vecs[5] = '{  6,   2, 1, 16'hA2AA, 1'b0, 0, 0,  0,  0,  0,  0,  0,  0};
    vecs[6] = '{  7,   3, 1, 16'hA28B, 1'b0, 0, 0,  0,  0,  0,  0,  0,  0};
    vecs[7] = '{ 12,   3, 4, 16'hF80A, 1'b0, 1, 16, 13,  4, 12, 15,  3,  6};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset overrun", int'(overrun), 0);
    check_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    $display("reset: outputs checked");

    for (int v = 0; v < 8; v++) begin
      o0 = ovr_cnt;
      send_frame(vecs[v].px, vecs[v].py, vecs[v].bs, vecs[v].color, vecs[v].full);
      wait_valid(lat);
      chk($sformatf("vec%0d latency", v), lat, LAT);
      check_out($sformatf("vec%0d", v), vecs[v].f, vecs[v].c, vecs[v].x, vecs[v].y,
                vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1);
      consume($sformatf("vec%0d", v));
      chk($sformatf("vec%0d no overrun", v), ovr_cnt, o0);
      $display("vec%0d: color=%h at (%0d,%0d) size %0d -> count=%0d cx=%0d cy=%0d",
               v, vecs[v].color, vecs[v].px, vecs[v].py, vecs[v].bs, pix_count, cx, cy);
    end

    // Two frames without ready: second publish overwrites and pulses overrun
    o0 = ovr_cnt;
    send_frame(5, 5, 1, 16'hF800, 1'b0);
    wait_valid(lat);
    chk("ovr first latency", lat, LAT);
    chk("ovr first cx", int'(cx), 5);
    send_frame(7, 9, 1, 16'hF800, 1'b0);
    chk("ovr hold valid", int'(out_valid), 1);
    chk("ovr hold cx", int'(cx), 5);
    repeat (LAT) @(posedge clk);
    #1;
    chk("ovr pulse", int'(overrun), 1);
    chk("ovr valid", int'(out_valid), 1);
    check_out("ovr second", 1, 1, 7, 9, 7, 7, 9, 9);
    @(posedge clk); #1;
    chk("ovr pulse width", int'(overrun), 0);
    chk("ovr count", ovr_cnt, o0+1);
    chk("ovr still valid", int'(out_valid), 1);
    $display("overrun: count=%0d cx=%0d cy=%0d pulses=%0d", pix_count, cx, cy, ovr_cnt-o0);

    // Ready in the publish cycle: new result loads, valid stays, no overrun
    o0 = ovr_cnt;
    send_frame(2, 3, 1, 16'hF800, 1'b0);
    repeat (LAT-1) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rdydone valid", int'(out_valid), 1);
    chk("rdydone overrun", int'(overrun), 0);
    check_out("rdydone", 1, 1, 2, 3, 2, 2, 3, 3);
    consume("rdydone");
    chk("rdydone ovr count", ovr_cnt, o0);
    $display("ready-at-done: cx=%0d cy=%0d", cx, cy);

    // Mid-frame restart discards the partial frame
    o0 = ovr_cnt;
    for (int i = 0; i < 5000; i++) write_px(i, 16'hF800);
    chk("restart no valid", int'(out_valid), 0);
    send_frame(3, 4, 1, 16'hF800, 1'b0);
    wait_valid(lat);
    chk("restart latency", lat, LAT);
    check_out("restart", 1, 1, 3, 4, 3, 3, 4, 4);
    consume("restart");
    chk("restart ovr count", ovr_cnt, o0);
    $display("restart: count=%0d cx=%0d cy=%0d", pix_count, cx, cy);

    // Reset during the x divide: no result, then a clean full frame
    send_frame(2, 2, 1, 16'hF800, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (LAT+20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("rstdiv no valid", seen, 0);
    chk("rstdiv pix_count", int'(pix_count), 0);
    send_frame(159, 119, 1, 16'hF800, 1'b1);
    wait_valid(lat);
    chk("rstdiv latency", lat, LAT);
    check_out("rstdiv frame", 1, 1, 159, 119, 159, 159, 119, 119);
    consume("rstdiv");
    $display("reset-mid-divide: next frame count=%0d cx=%0d cy=%0d", pix_count, cx, cy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
